// File: rtl/divider_unit_if.sv
// Start/done handshake bundle between the execute stage and the divider.
interface divider_if #(parameter int WIDTH = 32);
  logic             Start_i;
  logic [1:0]       Div_Operation_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             Busy_o;
  logic             Done_o;
  logic [WIDTH-1:0] Result_o;
  logic             Zero_o;

  // Requester side (execute stage / testbench)
  modport master (
    output Start_i, Div_Operation_i, A_i, B_i,
    input  Busy_o, Done_o, Result_o, Zero_o
  );

  // Divider side
  modport slave (
    input  Start_i, Div_Operation_i, A_i, B_i,
    output Busy_o, Done_o, Result_o, Zero_o
  );
endinterface

// File: rtl/divider_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  // Request decode: op[0]=0 means signed, op[1]=1 means remainder
  logic             w_signed;
  logic             w_is_rem;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_special_res;

  assign w_signed      = ~bus.Div_Operation_i[0];
  assign w_is_rem      = bus.Div_Operation_i[1];
  assign w_a_neg       = w_signed & bus.A_i[WIDTH-1];
  assign w_b_neg       = w_signed & bus.B_i[WIDTH-1];
  assign w_a_mag       = w_a_neg ? (~bus.A_i + 1'b1) : bus.A_i;
  assign w_b_mag       = w_b_neg ? (~bus.B_i + 1'b1) : bus.B_i;
  assign w_div0        = (bus.B_i == '0);
  assign w_ovf         = w_signed && (bus.A_i == W_MIN) && (bus.B_i == '1);
  assign w_special_res = w_div0 ? (w_is_rem ? bus.A_i : '1)
                                : (w_is_rem ? '0 : W_MIN);

  // One restoring step: the shifted remainder needs WIDTH+1 bits so the
  // trial subtraction's sign bit is meaningful.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_neg;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;
  logic [WIDTH-1:0] w_final;

  assign w_shift     = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_div};
  assign w_trial_neg = w_trial[WIDTH];
  assign w_next_rem  = w_trial_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_next_quo  = {r_quo[WIDTH-2:0], ~w_trial_neg};

  // Sign fix applied on the last step's outputs
  assign w_final = r_is_rem ? (r_neg_r ? (~w_next_rem + 1'b1) : w_next_rem)
                            : (r_neg_q ? (~w_next_quo + 1'b1) : w_next_quo);

  assign bus.Busy_o   = r_busy;
  assign bus.Done_o   = r_done;
  assign bus.Result_o = r_result;
  assign bus.Zero_o   = (r_result == '0);

  // Control FSM plus datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.Start_i) begin
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_busy   <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_count <= '0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem   <= w_next_rem;
          r_quo   <= w_next_quo;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH-1)) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed table, handshake corner
// sequences and random operations against an arithmetic reference model.
module tb_divider_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  divider_if #(.WIDTH(32)) bus ();
  divider_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics with plain arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (op[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF)
      return op[1] ? 32'h0 : 32'h80000000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (op[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one request; latency counts cycles from the accepting edge to the
  // Done_o sample. poke>0 re-asserts Start_i with junk operands mid-flight.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output logic [31:0] res, output logic zero,
                        output int lat, output int bcnt);
    logic done;
    @(negedge clk);
    bus.Start_i = 1'b1;
    bus.Div_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
    @(posedge clk); #1;
    bus.Start_i = 1'b0;
    bus.A_i = $urandom;
    bus.B_i = $urandom;
    lat = 0; bcnt = 0; done = 1'b0;
    while (!done && lat < 100) begin
      lat++;
      if (bus.Busy_o) bcnt++;
      if (bus.Done_o) done = 1'b1;
      else begin
        if (poke != 0 && lat == poke) begin
          bus.Start_i = 1'b1;
          bus.A_i = 32'd1;
          bus.B_i = 32'd1;
        end else bus.Start_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.Start_i = 1'b0;
    res = bus.Result_o;
    zero = bus.Zero_o;
    @(posedge clk); #1;
    chk("idle_after_done", {30'b0, bus.Busy_o, bus.Done_o}, 32'h0);
  endtask

  task automatic do_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat, input int poke);
    logic [31:0] res;
    logic zero;
    int lat, bcnt;
    run_op(op, a, b, poke, res, zero, lat, bcnt);
    chk({name, "_res"}, res, exp);
    chk({name, "_zero"}, {31'b0, zero}, {31'b0, (exp == 0)});
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_busy"}, bcnt, exp_lat);
  endtask

  initial begin
    logic [5:0] pat;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    bus.Start_i = 1'b0;
    bus.Div_Operation_i = 2'b00;
    bus.A_i = '0;
    bus.B_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.Busy_o}, 32'h0);
    chk("rst_done", {31'b0, bus.Done_o}, 32'h0);
    chk("rst_result", bus.Result_o, 32'h0);
    chk("rst_zero", {31'b0, bus.Zero_o}, 32'h1);
    @(negedge clk);
    reset = 1'b1;

    tbl.push_back('{"div_100_7",    2'b00, 32'd100,        32'd7,          32'd14,         33});
    tbl.push_back('{"rem_m7_2",     2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33});
    tbl.push_back('{"div_m7_2",     2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33});
    tbl.push_back('{"divu_big",     2'b01, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   33});
    tbl.push_back('{"remu_big",     2'b11, 32'hFFFFFFFF,   32'h10,         32'hF,          33});
    tbl.push_back('{"div_by0",      2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1});
    tbl.push_back('{"remu_by0",     2'b11, 32'd5,          32'd0,          32'd5,          1});
    tbl.push_back('{"div_ovf",      2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
    tbl.push_back('{"rem_ovf",      2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h0,          1});
    tbl.push_back('{"divu_noovf",   2'b01, 32'h80000000,   32'hFFFFFFFF,   32'h0,          33});
    tbl.push_back('{"div_7_m2",     2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33});
    tbl.push_back('{"rem_7_m2",     2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          33});
    tbl.push_back('{"div_min_2",    2'b00, 32'h80000000,   32'd2,          32'hC0000000,   33});
    tbl.push_back('{"divu_small",   2'b01, 32'd3,          32'd9,          32'd0,          33});
    for (int i = 0; i < tbl.size(); i++)
      do_vec(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, 0);

    // Start_i while busy must be ignored
    do_vec("busy_start_ignored", 2'b01, 32'd1000, 32'd10, 32'd100, 33, 10);

    // Start_i held high across special ops: accepted every other cycle
    @(negedge clk);
    bus.Start_i = 1'b1;
    bus.Div_Operation_i = 2'b00;
    bus.A_i = 32'd5;
    bus.B_i = 32'd0;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = bus.Done_o;
    end
    bus.Start_i = 1'b0;
    chk("b2b_done_pattern", {26'b0, pat}, 32'h15);
    @(posedge clk); #1;

    // Reset in the middle of CALC aborts with a cleared result
    @(negedge clk);
    bus.Start_i = 1'b1;
    bus.Div_Operation_i = 2'b01;
    bus.A_i = 32'd1000;
    bus.B_i = 32'd10;
    @(posedge clk); #1;
    bus.Start_i = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, bus.Busy_o}, 32'h0);
    chk("abort_done", {31'b0, bus.Done_o}, 32'h0);
    chk("abort_result", bus.Result_o, 32'h0);
    chk("abort_zero", {31'b0, bus.Zero_o}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    do_vec("after_abort", 2'b00, 32'd100, 32'd7, 32'd14, 33, 0);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        4: begin ra = 32'($urandom_range(0, 1000)); rb = $urandom; end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_vec($sformatf("rnd%0d", i), rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
